// File: rtl/sram_mem_bridge_if.sv
// Core-side memory port of the SRAM bridge (picorv32-style valid/ready bus).
// The core drives the request fields; the bridge answers with ready/rdata/error.
interface sram_mem_bridge_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_error;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, mem_error
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, mem_error
    );
endinterface

// File: rtl/sram_mem_bridge.sv
// Memory slave between the core memory port and a word-wide synchronous SRAM.
// Adds programmable wait states and reports out-of-range accesses on mem_error.
module sram_mem_bridge #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 0,
    localparam int         AW          = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_mem_bridge_if.slave     bus,
    output logic                 sram_en,
    output logic                 sram_we,
    output logic [3:0]           sram_be,
    output logic [AW-1:0]        sram_addr,
    output logic [31:0]          sram_wdata,
    input  logic [31:0]          sram_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, SRAM, RESP} state_t;

    localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

    state_t        state, state_nx;
    logic [3:0]    wait_cnt, wait_nx;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          err_q;
    logic          accept;
    logic          addr_err;
    logic          is_store;

    assign accept   = (state == IDLE) && bus.mem_valid;
    assign addr_err = ({1'b0, bus.mem_addr} < LO_ADDR) || ({1'b0, bus.mem_addr} >= HI_ADDR);
    assign is_store = (wstrb_q != 4'b0000);

    // The word index is latched rather than the raw address so that every
    // SRAM-side output reads zero after reset regardless of BASE_ADDR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            idx_q    <= '0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'h0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (accept) begin
                idx_q   <= AW'((bus.mem_addr - BASE_ADDR) >> 2);
                wdata_q <= bus.mem_wdata;
                wstrb_q <= bus.mem_wstrb;
                err_q   <= addr_err;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        wait_nx       = wait_cnt;
        sram_en       = 1'b0;
        sram_we       = 1'b0;
        sram_be       = 4'b0000;
        bus.mem_ready = 1'b0;
        bus.mem_error = 1'b0;
        bus.mem_rdata = 32'h0;
        case (state)
            IDLE: begin
                if (bus.mem_valid) begin
                    if (WAIT_STATES > 0) begin
                        state_nx = WAIT;
                        wait_nx  = 4'(WAIT_STATES - 1);
                    end else begin
                        state_nx = addr_err ? RESP : SRAM;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nx = err_q ? RESP : SRAM;
                end else begin
                    wait_nx = wait_cnt - 4'd1;
                end
            end
            SRAM: begin
                sram_en  = 1'b1;
                sram_we  = is_store;
                sram_be  = is_store ? wstrb_q : 4'b1111;
                state_nx = RESP;
            end
            RESP: begin
                bus.mem_ready = 1'b1;
                bus.mem_error = err_q;
                // SRAM read data arrives this cycle and is passed straight through.
                bus.mem_rdata = (!err_q && !is_store) ? sram_rdata : 32'h0;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign sram_addr  = idx_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_mem_bridge.sv
// Bench for sram_mem_bridge: a zero-wait and a three-wait instance, each with
// its own behavioural SRAM, checked against a shadow memory and a result queue.
module tb_sram_mem_bridge;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        v0 = 1'b0, v3 = 1'b0;
    logic        req_instr = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [3:0]  req_wstrb = 4'h0;
    logic        mem_init = 1'b1;

    sram_mem_bridge_if bus0 ();
    sram_mem_bridge_if bus3 ();

    assign bus0.mem_valid = v0;
    assign bus0.mem_instr = req_instr;
    assign bus0.mem_addr  = req_addr;
    assign bus0.mem_wdata = req_wdata;
    assign bus0.mem_wstrb = req_wstrb;
    assign bus3.mem_valid = v3;
    assign bus3.mem_instr = req_instr;
    assign bus3.mem_addr  = req_addr;
    assign bus3.mem_wdata = req_wdata;
    assign bus3.mem_wstrb = req_wstrb;

    logic        en0, we0, en3, we3;
    logic [3:0]  be0, be3;
    logic [9:0]  ad0, ad3;
    logic [31:0] wd0, wd3, rd0, rd3;

    sram_mem_bridge #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave),
        .sram_en(en0), .sram_we(we0), .sram_be(be0), .sram_addr(ad0),
        .sram_wdata(wd0), .sram_rdata(rd0)
    );

    sram_mem_bridge #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3.slave),
        .sram_en(en3), .sram_we(we3), .sram_be(be3), .sram_addr(ad3),
        .sram_wdata(wd3), .sram_rdata(rd3)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0001_0003);
    endfunction

    logic [31:0] mem0 [1024];
    logic [31:0] mem3 [1024];
    logic [31:0] shadow0 [1024];
    logic [31:0] shadow3 [1024];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem0[i] <= pat(i);
                mem3[i] <= pat(i);
            end
        end else begin
            if (en0) begin
                if (we0) begin
                    for (int b = 0; b < 4; b++)
                        if (be0[b]) mem0[ad0][8*b +: 8] <= wd0[8*b +: 8];
                end else rd0 <= mem0[ad0];
            end
            if (en3) begin
                if (we3) begin
                    for (int b = 0; b < 4; b++)
                        if (be3[b]) mem3[ad3][8*b +: 8] <= wd3[8*b +: 8];
                end else rd3 <= mem3[ad3];
            end
        end
    end

    bit          sel3 = 1'b0;
    logic        s_ready, s_err, s_en, s_we;
    logic [3:0]  s_be;
    logic [9:0]  s_addr;
    logic [31:0] s_rdata, s_wdata;

    always_comb begin
        s_ready = bus0.mem_ready; s_err = bus0.mem_error; s_rdata = bus0.mem_rdata;
        s_en = en0; s_we = we0; s_be = be0; s_addr = ad0; s_wdata = wd0;
        if (sel3) begin
            s_ready = bus3.mem_ready; s_err = bus3.mem_error; s_rdata = bus3.mem_rdata;
            s_en = en3; s_we = we3; s_be = be3; s_addr = ad3; s_wdata = wd3;
        end
    end

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_rdata_q [$];
    logic        exp_err_q [$];
    int          exp_lat_q [$];

    task automatic access(input bit w3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input bit hold, input bit scramble,
                          input string nm);
        logic        err;
        logic [9:0]  idx;
        logic [31:0] er, g_rd;
        logic [14:0] exp_side;
        logic        g_err;
        int          lat, cyc, en_cnt, en_cyc, g_lat;
        bit          done;
        err = (a >= 32'h1000);
        idx = a[11:2];
        lat = (err ? 1 : 2) + (w3 ? 3 : 0);
        er  = 32'h0;
        if (!err) begin
            if (st != 4'h0) begin
                for (int b = 0; b < 4; b++) if (st[b]) begin
                    if (w3) shadow3[idx][8*b +: 8] = wd[8*b +: 8];
                    else    shadow0[idx][8*b +: 8] = wd[8*b +: 8];
                end
            end else er = w3 ? shadow3[idx] : shadow0[idx];
        end
        exp_rdata_q.push_back(er);
        exp_err_q.push_back(err);
        exp_lat_q.push_back(lat);
        exp_side = {idx, (st != 4'h0), ((st != 4'h0) ? st : 4'hF)};

        sel3 = w3; req_addr = a; req_wdata = wd; req_wstrb = st; req_instr = (st == 4'h0);
        if (w3) v3 = 1'b1; else v0 = 1'b1;
        cyc = 0; en_cnt = 0; en_cyc = -1; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (s_en === 1'b1) begin
                en_cnt++; en_cyc = cyc;
                tests++;
                if ({s_addr, s_we, s_be} !== exp_side) begin
                    fails++;
                    $display("FAIL %s sram_ctl got addr/we/be=%h exp %h", nm, {s_addr, s_we, s_be}, exp_side);
                end
                if (st != 4'h0) begin
                    tests++;
                    if (s_wdata !== wd) begin
                        fails++;
                        $display("FAIL %s sram_wdata got %h exp %h", nm, s_wdata, wd);
                    end
                end
            end
            if (s_ready === 1'b1) begin
                done  = 1'b1;
                g_rd  = exp_rdata_q.pop_front();
                g_err = exp_err_q.pop_front();
                g_lat = exp_lat_q.pop_front();
                tests++;
                if (s_rdata !== g_rd) begin
                    fails++; $display("FAIL %s rdata got %h exp %h", nm, s_rdata, g_rd);
                end
                tests++;
                if (s_err !== g_err) begin
                    fails++; $display("FAIL %s mem_error got %b exp %b", nm, s_err, g_err);
                end
                tests++;
                if (cyc != g_lat) begin
                    fails++; $display("FAIL %s latency got %0d exp %0d", nm, cyc, g_lat);
                end
                tests++;
                if (g_err ? (en_cnt != 0) : (en_cnt != 1 || en_cyc != g_lat - 1)) begin
                    fails++; $display("FAIL %s sram_en count/cycle got %0d/%0d exp %0d/%0d",
                                      nm, en_cnt, en_cyc, g_err ? 0 : 1, g_err ? -1 : g_lat - 1);
                end
            end else begin
                tests++;
                if (s_rdata !== 32'h0 || s_err !== 1'b0) begin
                    fails++; $display("FAIL %s idle rdata/error got %h/%b exp 0/0", nm, s_rdata, s_err);
                end
            end
            @(posedge clk); #1;
            if (done) begin
                if (!hold) begin v0 = 1'b0; v3 = 1'b0; end
            end else begin
                cyc++;
                if (scramble && cyc == 1) begin
                    req_addr = ~a; req_wdata = ~wd; req_wstrb = ~st;
                end
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s timeout got no mem_ready exp ready in cycle %0d", nm, lat);
            void'(exp_rdata_q.pop_front()); void'(exp_err_q.pop_front()); void'(exp_lat_q.pop_front());
            v0 = 1'b0; v3 = 1'b0;
        end
        if (!hold) begin
            @(negedge clk);
            tests++;
            if (s_ready !== 1'b0) begin
                fails++; $display("FAIL %s ready_pulse got %b exp 0", nm, s_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({bus0.mem_ready, bus0.mem_error, bus0.mem_rdata, en0, we0, be0, ad0, wd0} !== '0) begin
            fails++; $display("FAIL reset_dut0 got %h exp 0",
                              {bus0.mem_ready, bus0.mem_error, bus0.mem_rdata, en0, we0, be0, ad0, wd0});
        end
        tests++;
        if ({bus3.mem_ready, bus3.mem_error, bus3.mem_rdata, en3, we3, be3, ad3, wd3} !== '0) begin
            fails++; $display("FAIL reset_dut3 got %h exp 0",
                              {bus3.mem_ready, bus3.mem_error, bus3.mem_rdata, en3, we3, be3, ad3, wd3});
        end
        mem_init = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        access(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, "sw_w0");
        access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, "lw_w0");
    endtask

    task automatic test_byte_store();
        access(1'b0, 32'h10, 32'h000000AA, 4'b0001, 1'b0, 1'b0, "sb_w0");
        access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, "lw_after_sb");
        access(1'b0, 32'h32, 32'h5566_7788, 4'b1100, 1'b0, 1'b0, "sh_hi_w0");
        access(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b0, "lw_after_sh");
    endtask

    task automatic test_wait_states();
        access(1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, "lw_w3_init");
        access(1'b1, 32'h84, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, "sw_w3");
        access(1'b1, 32'h84, 32'h0, 4'h0, 1'b0, 1'b1, "lw_w3_scrambled");
    endtask

    task automatic test_out_of_range();
        access(1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 1'b0, "lw_oor");
        access(1'b0, 32'hFFC, 32'h0, 4'h0, 1'b0, 1'b0, "lw_last_word");
        access(1'b0, 32'h2000, 32'h1111_2222, 4'hF, 1'b0, 1'b0, "sw_oor");
        access(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0, 1'b0, "lw_top");
        access(1'b1, 32'h1004, 32'h0, 4'h0, 1'b0, 1'b0, "lw_oor_w3");
    endtask

    task automatic test_mid_reset();
        int  n;
        bool_hit: begin end
        sel3 = 1'b0; req_addr = 32'h20; req_wdata = 32'h1234_5678; req_wstrb = 4'hF;
        req_instr = 1'b0; v0 = 1'b1;
        n = 0;
        @(negedge clk);
        while (s_en !== 1'b1 && n < 10) begin
            @(posedge clk); #1; @(negedge clk); n++;
        end
        tests++;
        if (s_en !== 1'b1) begin
            fails++; $display("FAIL midrst_reach_sram got sram_en=%b exp 1", s_en);
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if ({bus0.mem_ready, bus0.mem_error, bus0.mem_rdata, en0, we0, be0, ad0, wd0} !== '0) begin
            fails++; $display("FAIL midrst_outputs got %h exp 0",
                              {bus0.mem_ready, bus0.mem_error, bus0.mem_rdata, en0, we0, be0, ad0, wd0});
        end
        v0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, "lw_after_midrst");
    endtask

    task automatic test_back_to_back();
        access(1'b0, 32'h40, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b0, "b2b_sw");
        access(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0, "b2b_lw");
        access(1'b0, 32'h1100, 32'h0, 4'h0, 1'b1, 1'b0, "b2b_oor");
        access(1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 1'b0, "b2b_lw2");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            shadow0[i] = pat(i);
            shadow3[i] = pat(i);
        end
        test_reset();
        test_store_load();
        test_byte_store();
        test_wait_states();
        test_out_of_range();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
